// File: rtl/pwm_dimmer_gen.sv
// PWM generator for the LED dimmer. Converts the 4-bit brightness selection
// into a 15-slot PWM waveform. A new duty is adopted only at a period
// boundary, so the LED never sees a truncated or stretched pulse. The
// optional fade mode walks the active duty toward the target one level
// per period.
module pwm_dimmer_gen #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] duty_in,
    input  logic       enable,
    input  logic       fade_en,
    output logic       pwm_out,
    output logic       period_start,
    output logic [3:0] duty_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Last prescaler count before the slot advances; PRESCALE=1 gives 0,
    // which makes every RUN clock a slot tick.
    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    // Slots 0..14 form one period; duty 15 therefore means "always on".
    localparam logic [3:0]  SLOT_LAST = 4'd14;

    state_t      state_q, state_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [3:0]  slot_cnt_q, slot_cnt_d;
    logic [3:0]  duty_q, duty_d;
    logic        pwm_q, pwm_d;
    logic        pstart_q, pstart_d;

    logic        tick;
    logic        boundary;
    logic [3:0]  fade_step;

    assign tick     = (pre_cnt_q == PRE_LAST);
    assign boundary = tick && (slot_cnt_q == SLOT_LAST);

    // One fade step toward the target; strict compares mean it can never
    // overshoot the target or wrap past 0 or 15.
    always_comb begin
        fade_step = duty_q;
        if (duty_q < duty_in) begin
            fade_step = duty_q + 4'd1;
        end else if (duty_q > duty_in) begin
            fade_step = duty_q - 4'd1;
        end
    end

    // Next-state logic: FSM, prescaler, slot counter, boundary duty update
    // and the registered PWM compare.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        slot_cnt_d = slot_cnt_q;
        duty_d     = duty_q;
        pwm_d      = 1'b0;
        pstart_d   = 1'b0;

        case (state_q)
            IDLE: begin
                pre_cnt_d  = '0;
                slot_cnt_d = '0;
                duty_d     = duty_in;
                if (enable) begin
                    state_d  = RUN;
                    pstart_d = 1'b1;
                end
            end

            RUN: begin
                if (!enable) begin
                    state_d    = IDLE;
                    pre_cnt_d  = '0;
                    slot_cnt_d = '0;
                end else begin
                    pwm_d = (slot_cnt_q < duty_q);
                    if (tick) begin
                        pre_cnt_d = '0;
                        if (boundary) begin
                            slot_cnt_d = '0;
                            pstart_d   = 1'b1;
                            duty_d     = fade_en ? fade_step : duty_in;
                        end else begin
                            slot_cnt_d = slot_cnt_q + 4'd1;
                        end
                    end else begin
                        pre_cnt_d = pre_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            slot_cnt_q <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            pstart_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            pstart_q   <= pstart_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;
    assign duty_active  = duty_q;

endmodule
